// File: rtl/div_by_n_serial_pkg.sv
// Shared types for the serial divisibility checker: FSM states and bit-order modes.
package div_by_n_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;
endpackage

// File: rtl/div_by_n_serial_mod_add_reduce.sv
// Single conditional subtract: r = t mod D, valid whenever t < 2*D.
module mod_add_reduce
    import div_by_n_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic [DIV_W:0]   t_i,
    input  logic [DIV_W-1:0] d_i,
    output logic [DIV_W-1:0] r_o
);
    logic [DIV_W:0] diff;

    assign diff = t_i - {1'b0, d_i};
    assign r_o  = (t_i >= {1'b0, d_i}) ? diff[DIV_W-1:0] : t_i[DIV_W-1:0];
endmodule

// File: rtl/div_by_n_serial.sv
// Serial (value mod D) tracker over framed bitstreams, MSB- or LSB-first, with
// per-beat remainder, end-of-frame result pulse and protocol error pulse.
module div_by_n_serial
    import div_by_n_pkg::*;
#(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_lsb_first_i,
    input  logic             valid_i,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic             x_i,
    output logic [DIV_W-1:0] rem_o,
    output logic             div_o,
    output logic [CNT_W-1:0] len_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             err_o
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] d_q, d_d, rem_q, rem_d, pow_q, pow_d;
    logic             mode_q, mode_d, div_q, div_d, rv_q, rv_d, err_q, err_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic             sof_beat, mode_eff;
    logic [DIV_W-1:0] d_eff, rem_base, pow_base, rem_red, pow_red, rem_nxt, pow_nxt;
    logic [DIV_W:0]   rem_t, pow_t;

    // A SOF beat computes from fresh cfg and base state instead of the latched frame.
    assign sof_beat = valid_i & sof_i;
    assign d_eff    = sof_beat ? cfg_div_i : d_q;
    assign mode_eff = sof_beat ? cfg_lsb_first_i : mode_q;
    assign rem_base = sof_beat ? '0 : rem_q;
    assign pow_base = sof_beat ? ((cfg_div_i > DIV_W'(1)) ? DIV_W'(1) : '0) : pow_q;

    assign rem_t = (mode_eff == LSB_FIRST) ?
                   ({1'b0, rem_base} + (x_i ? {1'b0, pow_base} : '0)) :
                   {rem_base, x_i};
    assign pow_t = {pow_base, 1'b0};

    mod_add_reduce #(.DIV_W(DIV_W)) u_rem_red (.t_i(rem_t), .d_i(d_eff), .r_o(rem_red));
    mod_add_reduce #(.DIV_W(DIV_W)) u_pow_red (.t_i(pow_t), .d_i(d_eff), .r_o(pow_red));

    // D==0 pins both accumulators at zero; pow only advances in LSB-first mode.
    assign rem_nxt = (d_eff == '0) ? '0 : rem_red;
    assign pow_nxt = (d_eff == '0) ? '0 : ((mode_eff == LSB_FIRST) ? pow_red : pow_base);

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        pow_d   = pow_q;
        len_d   = len_q;
        div_d   = div_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        if (valid_i) begin
            if (sof_i) begin
                err_d  = (state_q == RUN) || (cfg_div_i == '0);
                d_d    = cfg_div_i;
                mode_d = cfg_lsb_first_i;
                len_d  = CNT_W'(1);
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                len_d = (&len_q) ? len_q : len_q + 1'b1;
            end
            if (sof_i || state_q == RUN) begin
                rem_d   = rem_nxt;
                pow_d   = pow_nxt;
                div_d   = (rem_nxt == '0) && (d_eff != '0);
                rv_d    = eof_i;
                state_d = eof_i ? IDLE : RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            mode_q  <= MSB_FIRST;
            rem_q   <= '0;
            pow_q   <= '0;
            len_q   <= '0;
            div_q   <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            pow_q   <= pow_d;
            len_q   <= len_d;
            div_q   <= div_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign rem_o          = rem_q;
    assign div_o          = div_q;
    assign len_o          = len_q;
    assign result_valid_o = rv_q;
    assign busy_o         = (state_q == RUN);
    assign err_o          = err_q;
endmodule

// File: tb/tb_div_by_n_serial.sv
// Bench for div_by_n_serial: directed vector table, reset/gap sequences and a
// random frame sweep checked against an arithmetic (value mod D) model.
module tb_div_by_n_serial;
    localparam int DIV_W   = 4;
    localparam int CNT_W   = 4;
    localparam int LEN_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DIV_W-1:0] cfg_div_i = '0;
    logic             cfg_lsb_first_i = 1'b0;
    logic             valid_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0, x_i = 1'b0;
    logic [DIV_W-1:0] rem_o;
    logic             div_o, result_valid_o, busy_o, err_o;
    logic [CNT_W-1:0] len_o;

    div_by_n_serial #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_div_i(cfg_div_i), .cfg_lsb_first_i(cfg_lsb_first_i),
        .valid_i(valid_i), .sof_i(sof_i), .eof_i(eof_i), .x_i(x_i),
        .rem_o(rem_o), .div_o(div_o), .len_o(len_o), .result_valid_o(result_valid_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // Reference model: the frame's numeric value kept as an integer, remainder by '%'.
    bit              m_run;
    int              m_d, m_idx, m_len;
    bit              m_lsb;
    longint unsigned m_val;
    int              e_rem, e_div, e_len, e_rv, e_err;

    task automatic model_reset();
        m_run = 0; m_d = 0; m_lsb = 0; m_val = 0; m_idx = 0; m_len = 0;
        e_rem = 0; e_div = 0; e_len = 0; e_rv = 0; e_err = 0;
    endtask

    task automatic model_beat(input int v, input int s, input int e, input int x,
                              input int d, input int lsb);
        e_rv = 0; e_err = 0;
        if (v == 0) return;
        if (s != 0) begin
            e_err = (m_run || d == 0) ? 1 : 0;
            m_d = d; m_lsb = (lsb != 0); m_val = 0; m_idx = 0; m_len = 0;
        end else if (!m_run) begin
            e_err = 1;
            return;
        end
        if (m_lsb) m_val = m_val + (longint'(x) << m_idx);
        else       m_val = m_val * 2 + longint'(x);
        m_idx++;
        if (m_len < LEN_MAX) m_len++;
        e_rem = (m_d == 0) ? 0 : int'(m_val % longint'(m_d));
        e_div = (m_d != 0 && e_rem == 0) ? 1 : 0;
        e_len = m_len;
        e_rv  = (e != 0) ? 1 : 0;
        m_run = (e == 0);
    endtask

    task automatic cmp(input string nm, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step(input int v, input int s, input int e, input int x,
                        input int d, input int lsb);
        @(negedge clk);
        valid_i = (v != 0); sof_i = (s != 0); eof_i = (e != 0); x_i = (x != 0);
        cfg_div_i = DIV_W'(d); cfg_lsb_first_i = (lsb != 0);
        @(posedge clk);
        model_beat(v, s, e, x, d, lsb);
        #1;
    endtask

    task automatic chk_model(input string tag);
        cmp({tag, ".rem"},  int'(rem_o), e_rem);
        cmp({tag, ".div"},  int'(div_o), e_div);
        cmp({tag, ".len"},  int'(len_o), e_len);
        cmp({tag, ".rv"},   int'(result_valid_o), e_rv);
        cmp({tag, ".err"},  int'(err_o), e_err);
        cmp({tag, ".busy"}, int'(busy_o), m_run ? 1 : 0);
    endtask

    task automatic chk_zero(input string tag);
        cmp({tag, ".rem"},  int'(rem_o), 0);
        cmp({tag, ".div"},  int'(div_o), 0);
        cmp({tag, ".len"},  int'(len_o), 0);
        cmp({tag, ".rv"},   int'(result_valid_o), 0);
        cmp({tag, ".err"},  int'(err_o), 0);
        cmp({tag, ".busy"}, int'(busy_o), 0);
    endtask

    typedef struct {
        int v, s, e, x, d, lsb;
        int rem, dv, len, rv, err, busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // v s e x  d lsb | rem div len rv err busy
        tbl.push_back('{1,1,0,1, 3,0, 1,0,1,0,0,1});   // D=3 MSB 1,1,0
        tbl.push_back('{1,0,0,1, 3,0, 0,1,2,0,0,1});
        tbl.push_back('{1,0,1,0, 3,0, 0,1,3,1,0,0});
        tbl.push_back('{1,1,0,1, 5,1, 1,0,1,0,0,1});   // D=5 LSB 1,0,1
        tbl.push_back('{1,0,0,0, 5,1, 1,0,2,0,0,1});
        tbl.push_back('{1,0,1,1, 5,1, 0,1,3,1,0,0});
        tbl.push_back('{1,1,0,1, 5,0, 1,0,1,0,0,1});   // D=5 MSB 1,0,1
        tbl.push_back('{1,0,0,0, 5,0, 2,0,2,0,0,1});
        tbl.push_back('{1,0,1,1, 5,0, 0,1,3,1,0,0});
        tbl.push_back('{1,1,1,0, 3,0, 0,1,1,1,0,0});   // single-beat frame
        tbl.push_back('{1,0,0,1, 3,0, 0,1,1,0,1,0});   // beat without SOF in IDLE
        tbl.push_back('{0,0,0,1, 3,0, 0,1,1,0,0,0});
        tbl.push_back('{1,1,0,1, 3,0, 1,0,1,0,0,1});   // SOF mid-frame aborts
        tbl.push_back('{1,0,0,1, 3,0, 0,1,2,0,0,1});
        tbl.push_back('{1,1,0,1, 5,0, 1,0,1,0,1,1});
        tbl.push_back('{1,0,0,1, 5,0, 3,0,2,0,0,1});
        tbl.push_back('{1,0,1,1, 5,0, 2,0,3,1,0,0});
        tbl.push_back('{1,1,0,1, 0,0, 0,0,1,0,1,1});   // D=0 frame
        tbl.push_back('{1,0,1,1, 0,0, 0,0,2,1,0,0});
        tbl.push_back('{1,1,0,1, 3,0, 1,0,1,0,0,1});   // cfg change mid-frame ignored
        tbl.push_back('{1,0,0,1, 5,1, 0,1,2,0,0,1});
        tbl.push_back('{1,0,1,0, 7,1, 0,1,3,1,0,0});

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].x, tbl[i].d, tbl[i].lsb);
            cmp($sformatf("tbl%0d.rem", i),  int'(rem_o), tbl[i].rem);
            cmp($sformatf("tbl%0d.div", i),  int'(div_o), tbl[i].dv);
            cmp($sformatf("tbl%0d.len", i),  int'(len_o), tbl[i].len);
            cmp($sformatf("tbl%0d.rv", i),   int'(result_valid_o), tbl[i].rv);
            cmp($sformatf("tbl%0d.err", i),  int'(err_o), tbl[i].err);
            cmp($sformatf("tbl%0d.busy", i), int'(busy_o), tbl[i].busy);
        end

        // D=7 MSB, sixteen ones with valid gaps (len saturates in this bench's CNT_W)
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 1) begin
                step(0, 0, 0, 0, 7, 0);
                chk_model("ffff_gap");
            end
            step(1, (i == 0) ? 1 : 0, (i == 15) ? 1 : 0, 1, 7, 0);
            chk_model("ffff");
        end
        cmp("ffff.final_rem", int'(rem_o), 65535 % 7);
        cmp("ffff.len_sat", int'(len_o), LEN_MAX);

        // Reset mid-frame: D=9, five bits in
        for (int i = 0; i < 5; i++) begin
            step(1, (i == 0) ? 1 : 0, 0, i % 2, 9, 0);
            chk_model("pre_rst");
        end
        @(negedge clk);
        valid_i = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, (i == 0) ? 1 : 0, (i == 4) ? 1 : 0, (i == 0 || i >= 3) ? 1 : 0, 9, 0);
            chk_model("post_rst");
        end
        cmp("post_rst.final_rem", int'(rem_o), 19 % 9);

        // Random frames, D=1..15, both bit orders, random gaps and mid-frame cfg noise
        for (int f = 0; f < 60; f++) begin
            int d, lsb, n;
            d   = int'($urandom_range(15, 1));
            lsb = int'($urandom_range(1, 0));
            n   = int'($urandom_range(32, 1));
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(3, 0) == 0) begin
                    step(0, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                         int'($urandom_range(1, 0)), d, lsb);
                    chk_model("rnd_gap");
                end
                if (i == 0)
                    step(1, 1, (n == 1) ? 1 : 0, int'($urandom_range(1, 0)), d, lsb);
                else
                    step(1, 0, (i == n - 1) ? 1 : 0, int'($urandom_range(1, 0)),
                         int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));
                chk_model("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
